// File: rtl/dds_sine_generator_if.sv
// rtl/dds_sine_generator_if.sv - control and sample bundle for the DDS sine generator
interface dds_sine_generator_if #(
  parameter int OUT_W   = 20,
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 16
);
  logic               enable;
  logic               sample_en;
  logic               sync;
  logic [PHASE_W-1:0] freq_word;
  logic [PHASE_W-1:0] phase_offset;
  logic [AMP_W-1:0]   amplitude;
  logic [OUT_W-1:0]   sine_out;
  logic               sine_valid;
  logic               phase_wrap;

  modport master (
    output enable, sample_en, sync, freq_word, phase_offset, amplitude,
    input  sine_out, sine_valid, phase_wrap
  );

  modport slave (
    input  enable, sample_en, sync, freq_word, phase_offset, amplitude,
    output sine_out, sine_valid, phase_wrap
  );
endinterface

// File: rtl/dds_sine_generator.sv
// rtl/dds_sine_generator.sv - phase accumulator DDS with quarter-wave ROM and amplitude scaling
// Four register stages: capture, ROM read, signed sample, scaled output.
module dds_sine_generator #(
  parameter int OUT_W   = 20,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int AMP_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dds_sine_generator_if.slave  bus
);
  localparam int LUT_N = 1 << LUT_AW;
  localparam int PW    = OUT_W + AMP_W;
  localparam logic [AMP_W-1:0]     AMP_ONE = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic signed [PW-1:0] ROUND_K = PW'(1) << (AMP_W-2);

  // Taylor series keeps the table a pure elaboration-time constant.
  function automatic logic [OUT_W-2:0] lut_value(input int k);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979323846 * ($itor(k) + 0.5) / $itor(2 * LUT_N);
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / ($itor(2 * n) * $itor(2 * n + 1));
      sum  = sum + term;
    end
    return (OUT_W-1)'($rtoi(sum * $itor((1 << (OUT_W-1)) - 1) + 0.5));
  endfunction

  logic [OUT_W-2:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [OUT_W-2:0] VAL = lut_value(k);
    assign lut[k] = VAL;
  end

  logic [PHASE_W-1:0]  acc;
  logic [PHASE_W-1:0]  acc_base;
  logic [PHASE_W:0]    acc_sum;
  logic [PHASE_W-1:0]  p_full;
  logic [LUT_AW+1:0]   p_top;
  logic [AMP_W-1:0]    a_eff;
  logic                active;

  logic                v0, v1, v2;
  logic [LUT_AW+1:0]   p0;
  logic [AMP_W-1:0]    amp0, amp1, amp2;
  logic                wrap0, wrap1, wrap2;
  logic [LUT_AW-1:0]   addr;
  logic [OUT_W-2:0]    rom1;
  logic                neg1;
  logic signed [OUT_W-1:0] s_next, s2;
  logic signed [PW-1:0]    prod, rnd;
  logic [OUT_W-1:0]    scaled;
  logic [OUT_W-1:0]    sine_out_r;
  logic                sine_valid_r;
  logic                phase_wrap_r;

  assign active = bus.enable & bus.sample_en;

  // A resync treats the accumulator as zero for the coincident sample too.
  assign acc_base = bus.sync ? '0 : acc;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, bus.freq_word};
  assign p_full   = acc_base + bus.phase_offset;
  assign p_top    = (LUT_AW+2)'(p_full >> (PHASE_W - LUT_AW - 2));
  assign a_eff    = (bus.amplitude > AMP_ONE) ? AMP_ONE : bus.amplitude;

  assign addr   = p0[LUT_AW] ? ~p0[LUT_AW-1:0] : p0[LUT_AW-1:0];
  assign s_next = neg1 ? -$signed({1'b0, rom1}) : $signed({1'b0, rom1});

  assign prod   = $signed(PW'(s2)) * $signed(PW'({1'b0, amp2}));
  assign rnd    = prod + ROUND_K;
  assign scaled = OUT_W'(rnd >>> (AMP_W-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      v0           <= 1'b0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      p0           <= '0;
      amp0         <= '0;
      amp1         <= '0;
      amp2         <= '0;
      wrap0        <= 1'b0;
      wrap1        <= 1'b0;
      wrap2        <= 1'b0;
      rom1         <= '0;
      neg1         <= 1'b0;
      s2           <= '0;
      sine_out_r   <= '0;
      sine_valid_r <= 1'b0;
      phase_wrap_r <= 1'b0;
    end else begin
      if (bus.sync || active)
        acc <= active ? acc_sum[PHASE_W-1:0] : '0;

      v0 <= active;
      if (active) begin
        p0    <= p_top;
        amp0  <= a_eff;
        wrap0 <= acc_sum[PHASE_W];
      end

      v1 <= v0;
      if (v0) begin
        rom1  <= lut[addr];
        neg1  <= p0[LUT_AW+1];
        amp1  <= amp0;
        wrap1 <= wrap0;
      end

      v2 <= v1;
      if (v1) begin
        s2    <= s_next;
        amp2  <= amp1;
        wrap2 <= wrap1;
      end

      sine_valid_r <= v2;
      phase_wrap_r <= v2 & wrap2;
      if (v2)
        sine_out_r <= scaled;
    end
  end

  assign bus.sine_out   = sine_out_r;
  assign bus.sine_valid = sine_valid_r;
  assign bus.phase_wrap = phase_wrap_r;
endmodule

// File: tb/tb_dds_sine_generator.sv
// tb/tb_dds_sine_generator.sv - directed self-checking bench for dds_sine_generator
module tb_dds_sine_generator;
  localparam int OUT_W   = 20;
  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 8;
  localparam int AMP_W   = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dds_sine_generator_if #(.OUT_W(OUT_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W)) bus ();

  dds_sine_generator #(
    .OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int v;
    bit w;
    int c;
  } obs_t;

  obs_t obs_q[$];
  int   cap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    obs_t o;
    if (bus.sine_valid === 1'b1) begin
      o.v = int'($signed(bus.sine_out));
      o.w = bus.phase_wrap;
      o.c = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic int ref_sample(input int unsigned phase);
    int  q;
    int  a;
    int  m;
    real x;
    q = int'((phase >> 22) & 3);
    a = int'((phase >> 14) & 255);
    if (q % 2 == 1) a = 255 - a;
    x = 3.141592653589793 * ($itor(a) + 0.5) / 512.0;
    m = $rtoi(524287.0 * $sin(x) + 0.5);
    return (q >= 2) ? -m : m;
  endfunction

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.enable       = 1'b1;
    bus.sample_en    = 1'b0;
    bus.sync         = 1'b0;
    bus.freq_word    = 24'h400000;
    bus.phase_offset = '0;
    bus.amplitude    = 16'd32768;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete();
    cap_q.delete();
  endtask

  task automatic strobe(input bit with_sync);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.sync      = with_sync;
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.sync      = 1'b0;
    cap_q.push_back(cyc);
  endtask

  task automatic sync_pulse();
    @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.sine_out !== '0) begin
      errors++;
      $display("FAIL reset_sine_out got %0d want 0", bus.sine_out);
    end
    checks++;
    if (bus.sine_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_sine_valid got %b want 0", bus.sine_valid);
    end
    checks++;
    if (bus.phase_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_phase_wrap got %b want 0", bus.phase_wrap);
    end
  endtask

  task automatic test_quadrants();
    int exp_v[4] = '{1608, 524285, -1608, -524285};
    do_reset();
    repeat (4) strobe(1'b0);
    drain();
    checks++;
    if (obs_q.size() !== 4) begin
      errors++;
      $display("FAIL quad_count got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].v !== exp_v[i]) begin
        errors++;
        $display("FAIL quad_value[%0d] got %0d want %0d", i, obs_q[i].v, exp_v[i]);
      end
      checks++;
      if (obs_q[i].w !== (i == 3)) begin
        errors++;
        $display("FAIL quad_wrap[%0d] got %b want %b", i, obs_q[i].w, (i == 3));
      end
      checks++;
      if (obs_q[i].c - cap_q[i] !== 3) begin
        errors++;
        $display("FAIL quad_latency[%0d] got %0d want 3", i, obs_q[i].c - cap_q[i]);
      end
    end
  endtask

  task automatic test_half_amplitude();
    int exp_v[4] = '{804, 262143, -804, -262142};
    do_reset();
    bus.amplitude = 16'd16384;
    repeat (4) strobe(1'b0);
    drain();
    checks++;
    if (obs_q.size() !== 4) begin
      errors++;
      $display("FAIL half_count got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].v !== exp_v[i]) begin
        errors++;
        $display("FAIL half_value[%0d] got %0d want %0d", i, obs_q[i].v, exp_v[i]);
      end
    end
  endtask

  task automatic test_phase_offset_sync();
    int exp_v[7] = '{-1608, -524285, -1608, -524285, 1608, -1608, -524285};
    do_reset();
    bus.phase_offset = 24'h800000;
    strobe(1'b0);
    strobe(1'b0);
    sync_pulse();
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    drain();
    checks++;
    if (obs_q.size() !== 7) begin
      errors++;
      $display("FAIL offset_count got %0d want 7", obs_q.size());
    end
    for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].v !== exp_v[i] || obs_q[i].w !== 1'b0) begin
        errors++;
        $display("FAIL offset_value[%0d] got %0d/%b want %0d/0", i, obs_q[i].v, obs_q[i].w, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned ph;
    do_reset();
    bus.freq_word = 24'h040000;
    @(negedge clk);
    bus.sample_en = 1'b1;
    repeat (256) @(negedge clk);
    bus.sample_en = 1'b0;
    drain();
    checks++;
    if (obs_q.size() !== 256) begin
      errors++;
      $display("FAIL b2b_count got %0d want 256", obs_q.size());
    end
    for (int n = 0; n < obs_q.size() && n < 256; n++) begin
      ph = (n << 18) & 32'h00FFFFFF;
      checks++;
      if (obs_q[n].v !== ref_sample(ph)) begin
        errors++;
        $display("FAIL b2b_value[%0d] got %0d want %0d", n, obs_q[n].v, ref_sample(ph));
      end
      checks++;
      if (obs_q[n].w !== ((n + 1) % 64 == 0)) begin
        errors++;
        $display("FAIL b2b_wrap[%0d] got %b want %b", n, obs_q[n].w, ((n + 1) % 64 == 0));
      end
      if (n > 0) begin
        checks++;
        if (obs_q[n].c - obs_q[n-1].c !== 1) begin
          errors++;
          $display("FAIL b2b_spacing[%0d] got %0d want 1", n, obs_q[n].c - obs_q[n-1].c);
        end
      end
      if (n + 32 < obs_q.size()) begin
        checks++;
        if (obs_q[n+32].v !== -obs_q[n].v) begin
          errors++;
          $display("FAIL b2b_symmetry[%0d] got %0d want %0d", n, obs_q[n+32].v, -obs_q[n].v);
        end
      end
    end
  endtask

  task automatic test_gating();
    do_reset();
    strobe(1'b0);
    strobe(1'b0);
    drain();
    bus.enable = 1'b0;
    repeat (10) strobe(1'b0);
    drain();
    checks++;
    if (obs_q.size() !== 2) begin
      errors++;
      $display("FAIL gate_no_valid got %0d want 2", obs_q.size());
    end
    checks++;
    if ($signed(bus.sine_out) !== 20'sd524285) begin
      errors++;
      $display("FAIL gate_hold got %0d want 524285", $signed(bus.sine_out));
    end
    bus.enable = 1'b1;
    strobe(1'b0);
    strobe(1'b0);
    drain();
    checks++;
    if (obs_q.size() !== 4) begin
      errors++;
      $display("FAIL gate_resume_count got %0d want 4", obs_q.size());
    end else begin
      checks++;
      if (obs_q[2].v !== -1608 || obs_q[3].v !== -524285) begin
        errors++;
        $display("FAIL gate_resume got %0d,%0d want -1608,-524285", obs_q[2].v, obs_q[3].v);
      end
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    strobe(1'b0);
    drain();
    checks++;
    if ($signed(bus.sine_out) !== 20'sd1608) begin
      errors++;
      $display("FAIL inflight_pre got %0d want 1608", $signed(bus.sine_out));
    end
    @(negedge clk);
    bus.sample_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.sample_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.sine_out !== '0 || bus.sine_valid !== 1'b0 || bus.phase_wrap !== 1'b0) begin
      errors++;
      $display("FAIL inflight_async got %0d/%b/%b want 0/0/0", bus.sine_out, bus.sine_valid, bus.phase_wrap);
    end
    obs_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drain();
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL inflight_discard got %0d valids want 0", obs_q.size());
    end
  endtask

  task automatic test_amplitude_clamp();
    int exp_v[4] = '{1608, 524285, -1608, -524285};
    do_reset();
    bus.amplitude = 16'd65535;
    repeat (4) strobe(1'b0);
    drain();
    checks++;
    if (obs_q.size() !== 4) begin
      errors++;
      $display("FAIL clamp_count got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].v !== exp_v[i]) begin
        errors++;
        $display("FAIL clamp_value[%0d] got %0d want %0d", i, obs_q[i].v, exp_v[i]);
      end
    end
  endtask

  initial begin
    bus.enable       = 1'b1;
    bus.sample_en    = 1'b0;
    bus.sync         = 1'b0;
    bus.freq_word    = 24'h400000;
    bus.phase_offset = '0;
    bus.amplitude    = 16'd32768;
    test_reset();
    test_quadrants();
    test_half_amplitude();
    test_phase_offset_sync();
    test_back_to_back();
    test_gating();
    test_reset_inflight();
    test_amplitude_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_sine_generator.md
# dds_sine_generator

Parametrised direct-digital-synthesis sine source for the sigma-delta DAC test chain. It is the successor to the fixed 176-entry LUT generator. A phase accumulator drives a quarter-wave ROM, which gives run-time frequency, phase offset and amplitude control plus phase resync. It sits ahead of the modulator, clocked by the system clock, and produces one sample per `sample_en` strobe.

## Interface
- `OUT_W`, 20: output sample width, signed two's complement.
- `PHASE_W`, 24: phase accumulator width. Must satisfy `PHASE_W >= LUT_AW+2`.
- `LUT_AW`, 8: quarter-wave ROM address width, giving 2^LUT_AW entries.
- `AMP_W`, 16: amplitude control width.

- `clk`  in  1  single system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  generator run; when low, `sample_en` is ignored.
- `sample_en`  in  1  one-cycle sample-rate strobe; may be high every cycle.
- `sync`  in  1  phase resync; clears the accumulator.
- `freq_word`  in  PHASE_W  phase increment per sample, unsigned.
- `phase_offset`  in  PHASE_W  phase added to the accumulator for each sample.
- `amplitude`  in  AMP_W  gain, where 2^(AMP_W-1) is unity.
- `sine_out`  out  OUT_W  signed scaled sample, registered.
- `sine_valid`  out  1  one-cycle pulse; `sine_out` is updated this cycle.
- `phase_wrap`  out  1  asserted with `sine_valid` when this sample's accumulator update overflowed.

## Operation
- **Capture:** an active sample is a cycle with `enable & sample_en`. On it:
  - sample phase p = acc + `phase_offset` (mod 2^PHASE_W), using acc before update;
  - acc <= acc + `freq_word`, and the carry-out is recorded as that sample's wrap;
  - `amplitude` is captured with p.
- **Sync:**
  - `sync` without an active sample: acc <= 0.
  - `sync` with an active sample: p = `phase_offset`, acc <= `freq_word`, wrap = 0.
  - `sync` has priority over `enable`.
- **Decode:**
  - quadrant q = p[PHASE_W-1:PHASE_W-2];
  - addr a = p[PHASE_W-3:PHASE_W-2-LUT_AW]; lower bits are truncated;
  - for q=1 and q=3, a is replaced by ~a (mirror);
  - for q=2 and q=3, the ROM value is negated.
- **ROM:**
  - lut[k] = round((2^(OUT_W-1)-1) * sin(pi/2*(k+0.5)/2^LUT_AW)), always positive;
  - contents are computed at elaboration from the parameters, so there is no external file;
  - negation never overflows.
- **Scaling:**
  - a_eff = min(`amplitude`, 2^(AMP_W-1));
  - out = (s*a_eff + 2^(AMP_W-2)) >>> (AMP_W-1), an arithmetic shift with round-half-up;
  - the product is OUT_W+AMP_W bits signed;
  - at unity gain out == s exactly; no saturation is needed.
- **enable low:**
  - no new samples are captured and acc holds;
  - samples already in the pipeline complete;
  - `sine_out` holds its last value.

## Timing
- Pipeline has 4 register stages:
  - E0: capture p, a_eff, wrap;
  - E1: ROM read plus registered quadrant;
  - E2: signed sample s;
  - E3: scaled output.
- `sine_valid` and `phase_wrap` pulse in the cycle after E3, i.e. 3 clocks after the capture edge.
- Full throughput: one sample per clock when `sample_en` is held high. Valids keep the same spacing as the strobes.
- Mid-stream changes to `freq_word`, `amplitude` or `phase_offset` affect only samples captured after the change. There are no glitches on samples in flight.
- Reset (async assert, sync deassert handled externally):
  - acc = 0, all pipeline valids = 0;
  - `sine_out` = 0, `sine_valid` = 0, `phase_wrap` = 0;
  - in-flight samples are discarded.
- Accumulator wrap-around is modulo 2^PHASE_W with no other special handling.

## Test plan
Default parameters throughout.

1. **Quadrant sequence.** After reset, set `freq_word`=2^22, `amplitude`=32768, `phase_offset`=0, and pulse `sample_en` four times.
   - `sine_out` = 1608, 524285, -1608, -524285.
   - `phase_wrap` = 1 on the 4th sample only.
   - Each valid arrives 3 clocks after its strobe.
2. **Half amplitude.** Repeat scenario 1 with `amplitude`=16384.
   - `sine_out` = 804, 262143, -804, -262142.
3. **Phase offset and resync.**
   - With `phase_offset`=2^23, the first sample is -1608.
   - Pulse `sync` mid-stream: the next sample restarts the sequence from phase 2^23.
   - `sync` coincident with a strobe: that sample is -1608 and the next one is -524285.
4. **Continuous strobe.** Hold `sample_en` high for 256 cycles with `freq_word`=2^18.
   - 256 consecutive valids covering 4 periods.
   - Waveform is symmetric: sample n+32 = -sample n.
   - `phase_wrap` on samples 64, 128, 192 and 256.
5. **Gating and reset.**
   - Drop `enable` for 10 strobes: no valids after the pipeline drains, `sine_out` holds, and the sequence resumes at the held phase.
   - Assert `reset_n` low with 2 samples in flight: outputs go to 0 immediately and no valid follows.
6. **Amplitude clamp.** Set `amplitude`=65535.
   - Output is identical to `amplitude`=32768.
